reset_requester: RTL and testbench



---
 rtl/reset_req_pkg.sv | 12 +
 rtl/reset_requester.sv | 116 +++++++++++
 tb/tb_reset_requester.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/reset_req_pkg.sv
// Shared encodings for the reset requester: FSM state codes and the width
// of the saturating pulse counter reported to the status registers.
package reset_req_pkg;

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_WATCH    = 2'd1;
    localparam logic [1:0] ST_PULSE    = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    localparam int PCNT_W = 8;

endpackage

// File: rtl/reset_requester.sv
// Watchdog / soft-reset pulse generator: issues a fixed-width active-low
// reset request on heartbeat timeout or software request, then holds off.
module reset_requester
    import reset_req_pkg::*;
#(
    parameter int TIMEOUT   = 1024,
    parameter int PULSE_LEN = 8,
    parameter int HOLDOFF   = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_kick,
    input  logic              i_sw_req,
    input  logic              i_timeout_clr,
    output logic              o_reset_req_n,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [PCNT_W-1:0] o_pulse_cnt
);

    localparam int MAX_AB = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
    localparam int MAX_V  = (MAX_AB > HOLDOFF) ? MAX_AB : HOLDOFF;
    localparam int CNT_W  = $clog2(MAX_V + 1);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF - 1);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("reset_requester: TIMEOUT must be >= 2");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse_len
        $error("reset_requester: PULSE_LEN must be >= 1");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("reset_requester: HOLDOFF must be >= 1");
    end

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_n;
    logic              r_busy;
    logic              r_timeout;
    logic [PCNT_W-1:0] r_pulse_cnt;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_set_timeout;
    logic              w_enter_pulse;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_DISABLED: begin
                if (i_sw_req)      w_state_nxt = ST_PULSE;
                else if (i_enable) w_state_nxt = ST_WATCH;
            end
            ST_WATCH: begin
                if (i_sw_req)            w_state_nxt = ST_PULSE;
                else if (!i_enable)      w_state_nxt = ST_DISABLED;
                else if (i_kick)         w_cnt_nxt   = '0;
                else if (r_cnt == TO_LAST) begin
                    w_state_nxt   = ST_PULSE;
                    w_set_timeout = 1'b1;
                end
                else                     w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_PULSE: begin
                if (r_cnt == PL_LAST) w_state_nxt = ST_HOLDOFF;
                else                  w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_HOLDOFF: begin
                if (r_cnt == HO_LAST) w_state_nxt = i_enable ? ST_WATCH : ST_DISABLED;
                else                  w_cnt_nxt   = r_cnt + 1'b1;
            end
            default: w_state_nxt = ST_DISABLED;
        endcase
        // The single counter restarts from zero in every new phase.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
        w_enter_pulse = (w_state_nxt == ST_PULSE) && (r_state != ST_PULSE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_DISABLED;
            r_cnt       <= '0;
            r_req_n     <= 1'b1;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req_n <= (w_state_nxt != ST_PULSE);
            r_busy  <= (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_HOLDOFF);
            // A timeout landing in the same cycle as a clear must stay visible.
            if (w_set_timeout)      r_timeout <= 1'b1;
            else if (i_timeout_clr) r_timeout <= 1'b0;
            if (w_enter_pulse && (r_pulse_cnt != '1))
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
        end
    end

    assign o_reset_req_n = r_req_n;
    assign o_busy        = r_busy;
    assign o_timeout     = r_timeout;
    assign o_pulse_cnt   = r_pulse_cnt;

endmodule

// File: tb/tb_reset_requester.sv
// Directed self-checking bench for reset_requester with TIMEOUT=16,
// PULSE_LEN=4, HOLDOFF=8.
module tb_reset_requester;
    import reset_req_pkg::*;

    logic       clk;
    logic       i_reset, i_enable, i_kick, i_sw_req, i_timeout_clr;
    logic       o_reset_req_n, o_busy, o_timeout;
    logic [7:0] o_pulse_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reset_requester #(.TIMEOUT(16), .PULSE_LEN(4), .HOLDOFF(8)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_kick        (i_kick),
        .i_sw_req      (i_sw_req),
        .i_timeout_clr (i_timeout_clr),
        .o_reset_req_n (o_reset_req_n),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout),
        .o_pulse_cnt   (o_pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, settling 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int low_cnt;
        int busy_cnt;
        int any_low;

        i_reset = 1'b1; i_enable = 1'b0; i_kick = 1'b0;
        i_sw_req = 1'b0; i_timeout_clr = 1'b0;
        tick(2);
        check("rst_req_n",   {31'd0, o_reset_req_n}, 32'd1);
        check("rst_busy",    {31'd0, o_busy},        32'd0);
        check("rst_timeout", {31'd0, o_timeout},     32'd0);
        check("rst_cnt",     {24'd0, o_pulse_cnt},   32'd0);
        check("rst_state",   {30'd0, dut.r_state},   {30'd0, ST_DISABLED});

        // Timeout: no kicks after entering WATCH
        i_reset = 1'b0; i_enable = 1'b1;
        tick(1);
        check("to_state_watch", {30'd0, dut.r_state}, {30'd0, ST_WATCH});
        tick(15);
        check("to_pre_req_n", {31'd0, o_reset_req_n}, 32'd1);
        check("to_pre_busy",  {31'd0, o_busy},        32'd0);
        tick(1);
        check("to_req_n",    {31'd0, o_reset_req_n}, 32'd0);
        check("to_timeout",  {31'd0, o_timeout},     32'd1);
        check("to_pulse_cnt",{24'd0, o_pulse_cnt},   32'd1);
        low_cnt = 1; busy_cnt = 1;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            if (!o_reset_req_n) low_cnt++;
            if (o_busy) busy_cnt++;
        end
        check("to_low_len",  low_cnt,  32'd4);
        check("to_busy_len", busy_cnt, 32'd12);
        tick(1);
        check("to_busy_end", {31'd0, o_busy}, 32'd0);
        check("to_back_watch", {30'd0, dut.r_state}, {30'd0, ST_WATCH});

        i_timeout_clr = 1'b1;
        tick(1);
        i_timeout_clr = 1'b0;
        check("to_clear", {31'd0, o_timeout}, 32'd0);

        // Kicks every 15 cycles keep the watchdog quiet
        any_low = 0;
        for (int i = 0; i < 200; i++) begin
            i_kick = (i % 15 == 0);
            tick(1);
            if (!o_reset_req_n) any_low = 1;
        end
        i_kick = 1'b1;
        tick(1);
        i_kick = 1'b0;
        check("kick_no_pulse", any_low, 32'd0);
        check("kick_cnt",      {24'd0, o_pulse_cnt}, 32'd1);

        // Timeout set and clear in the same cycle: set wins
        tick(15);
        check("tc_pre_req_n", {31'd0, o_reset_req_n}, 32'd1);
        i_timeout_clr = 1'b1;
        tick(1);
        i_timeout_clr = 1'b0;
        check("tc_set_wins", {31'd0, o_timeout},     32'd1);
        check("tc_req_n",    {31'd0, o_reset_req_n}, 32'd0);
        check("tc_cnt",      {24'd0, o_pulse_cnt},   32'd2);
        i_timeout_clr = 1'b1;
        tick(1);
        i_timeout_clr = 1'b0;
        check("tc_clear_in_pulse", {31'd0, o_timeout}, 32'd0);
        wait_idle("tc_idle");

        // Software request while disabled
        i_enable = 1'b0;
        tick(1);
        check("sw_disabled", {30'd0, dut.r_state}, {30'd0, ST_DISABLED});
        i_sw_req = 1'b1;
        tick(1);
        i_sw_req = 1'b0;
        check("sw_req_n_1",  {31'd0, o_reset_req_n}, 32'd0);
        check("sw_cnt",      {24'd0, o_pulse_cnt},   32'd3);
        check("sw_timeout",  {31'd0, o_timeout},     32'd0);
        tick(3);
        check("sw_req_n_4",  {31'd0, o_reset_req_n}, 32'd0);
        tick(1);
        check("sw_req_n_5",  {31'd0, o_reset_req_n}, 32'd1);
        check("sw_busy_ho",  {31'd0, o_busy},        32'd1);
        i_sw_req = 1'b1;
        tick(1);
        i_sw_req = 1'b0;
        tick(1);
        check("sw_ho_drop_req_n", {31'd0, o_reset_req_n}, 32'd1);
        check("sw_ho_drop_cnt",   {24'd0, o_pulse_cnt},   32'd3);
        tick(5);
        check("sw_ho_busy_last", {31'd0, o_busy}, 32'd1);
        tick(1);
        check("sw_ho_busy_end",  {31'd0, o_busy}, 32'd0);
        check("sw_ho_exit_state", {30'd0, dut.r_state}, {30'd0, ST_DISABLED});

        // Kick and software request in the same WATCH cycle
        i_enable = 1'b1;
        tick(1);
        i_kick = 1'b1; i_sw_req = 1'b1;
        tick(1);
        i_kick = 1'b0; i_sw_req = 1'b0;
        check("sim_req_n",   {31'd0, o_reset_req_n}, 32'd0);
        check("sim_timeout", {31'd0, o_timeout},     32'd0);
        check("sim_cnt",     {24'd0, o_pulse_cnt},   32'd4);
        wait_idle("sim_idle");
        check("sim_single",  {24'd0, o_pulse_cnt},   32'd4);

        // Reset in the second PULSE cycle
        i_sw_req = 1'b1;
        tick(1);
        i_sw_req = 1'b0;
        tick(1);
        check("mid_in_pulse", {31'd0, o_reset_req_n}, 32'd0);
        i_reset = 1'b1; i_enable = 1'b0;
        tick(1);
        check("mid_req_n", {31'd0, o_reset_req_n}, 32'd1);
        check("mid_busy",  {31'd0, o_busy},        32'd0);
        check("mid_cnt",   {24'd0, o_pulse_cnt},   32'd0);
        check("mid_state", {30'd0, dut.r_state},   {30'd0, ST_DISABLED});
        i_reset = 1'b0;

        // Pulse counter saturation
        for (int p = 1; p <= 260; p++) begin
            i_sw_req = 1'b1;
            tick(1);
            i_sw_req = 1'b0;
            if (p == 255) check("sat_255", {24'd0, o_pulse_cnt}, 32'd255);
            wait_idle("sat_idle");
        end
        check("sat_no_wrap", {24'd0, o_pulse_cnt}, 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
